hamming_mem_engine: RTL and testbench
=====================================

Name: hamming_mem_engine

Overview:
- Memory-mapped Hamming (16,11) SECDED engine; the hardware successor to the software encode program.
- On a start pulse, walks NUM_MSG byte-pairs in data memory and writes each result to a destination region.
- Two modes: encode (11-bit message to 16-bit codeword) and decode (codeword to corrected 11-bit message plus error flags).
- Sits beside the core on the byte-wide data-memory port and is driven by the same start/done handshake as the processor top level.

Parameters:
- NUM_MSG, 15: messages processed per start.
- AW, 8: memory address width.
- SRC_BASE, 0: byte address of the first source pair.
- DST_BASE, 30: byte address of the first destination pair.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request pulse.
- mode  in  1  0 = encode, 1 = decode; sampled when start is accepted.
- done  out  1  high after the last write, held until the next accepted start or reset.
- busy  out  1  high from start acceptance until done rises.
- mem_addr  out  AW  byte address for the read or write.
- mem_rd_data  in  8  read data; valid the cycle after mem_addr is presented (synchronous read).
- mem_wr_en  out  1  write strobe.
- mem_wr_data  out  8  write data.

Behaviour:
- Reset values: done=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0. FSM goes to IDLE and the message index resets to 0. Reset mid-operation aborts with no further writes.
- Pair layout:
  - Message i source: low byte at SRC_BASE+2i, high byte at SRC_BASE+2i+1.
  - Message i destination: low byte at DST_BASE+2i, high byte at DST_BASE+2i+1.
- Encode:
  - d[11:1] = {hi[2:0], lo}; hi[7:3] is ignored.
  - Codeword bit k is Hamming position k: [15:9]=d11..d5, [8]=p8, [7:5]=d4..d2, [4]=p4, [3]=d1, [2]=p2, [1]=p1, [0]=p0.
  - p8=^d[11:5]; p4=^d[11:8]^^d[4:2]; p2=d11^d10^d7^d6^d4^d3^d1; p1=d11^d9^d7^d5^d4^d2^d1.
  - p0 = even overall parity of the 16 bits.
- Decode:
  - Codeword w = {hi, lo}. Syndrome s[3:0] = XOR of indices k (1..15) where w[k]=1. Overall parity P = ^w.
  - s=0, P=0: F=00, no error.
  - P=1: single error; flip w[s] (s=0 means p0 only); F=01.
  - s!=0, P=0: double error; F=10; data extracted uncorrected.
  - Output: hi = {F[1:0], 3'b000, d11..d9}, lo = d8..d1.
- FSM states: IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, DONE.
  - IDLE/DONE -> RD_LO on start. This clears done, sets busy, latches mode, and sets i=0.
  - RD_LO: drive the low source address.
  - RD_HI: drive the high source address; capture the low byte.
  - CAP: capture the high byte; compute the result combinationally and register it.
  - WR_LO: write the low destination byte.
  - WR_HI: write the high destination byte. If i==NUM_MSG-1, go to DONE; else i++ and go to RD_LO.
  - DONE: done=1, busy=0.
- Latency: 5 cycles per message. done rises 5*NUM_MSG+1 cycles after the start edge.
- Boundaries:
  - start while busy is ignored.
  - start in DONE restarts immediately.
  - mem_wr_en is high only in WR_LO and WR_HI.
  - Overlapping source and destination regions are the user's responsibility; reads of a pair always complete before its writes.
  - Address arithmetic wraps modulo 2^AW.
  - The index counter is $clog2(NUM_MSG+1) bits wide.

Optional Feature:
- Macro: HAMMING_STATS_EN.
- When defined:
  - Adds outputs err1_cnt and err2_cnt, each $clog2(NUM_MSG+1) bits.
  - They count F=01 and F=10 results in decode mode.
  - Both clear on reset and on start acceptance, increment in WR_HI, and hold after done. Encode mode leaves them at 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Encode, source pair 0 = 0x01,0x00 (d=0x001) -> dest {hi,lo} = 0x00,0x0F; done 5*NUM_MSG+1 cycles after start.
- Encode d=0x7FF (bytes 0xFF,0x07) -> 0xFF,0xFF; d=0x000 -> 0x00,0x00; stray hi[7:3] bits ignored.
- Decode w=0x020F (0x000F with bit 9 flipped) -> hi=0x40, lo=0x01; w=0x000E (p0 flipped) -> hi=0x40, lo=0x01.
- Decode w=0x000C (two errors) -> hi=0x80, lo=0x01; w=0x000F -> hi=0x00, lo=0x01. With HAMMING_STATS_EN: err1_cnt and err2_cnt match the injected counts.
- Assert reset during WR_LO of message 3 -> no further mem_wr_en; done=0, busy=0; a new start processes all NUM_MSG messages from message 0.
- Pulse start again while busy -> ignored; exactly 2*NUM_MSG writes; done stays high until the next start after DONE.

Source files
------------

// File: rtl/hamming_mem_engine.sv
// Memory-mapped Hamming (16,11) SECDED encode/decode engine walking NUM_MSG byte pairs.
// Optional per-run error counters are enabled with `define HAMMING_STATS_EN.
module hamming_mem_engine #(
  parameter int NUM_MSG  = 15,
  parameter int AW       = 8,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
`ifdef HAMMING_STATS_EN
  ,
  output logic [$clog2(NUM_MSG+1)-1:0] err1_cnt,
  output logic [$clog2(NUM_MSG+1)-1:0] err2_cnt
`endif
);

  localparam int IW = $clog2(NUM_MSG + 1);
  localparam logic [AW-1:0] SRC_A = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A = AW'(DST_BASE);

  typedef enum logic [2:0] {S_IDLE, S_RD_LO, S_RD_HI, S_CAP, S_WR_LO, S_WR_HI, S_DONE} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic          mode_r;
  logic [7:0]    lo_r;
  logic [15:0]   res;
  logic [AW-1:0] off;
  logic          last;
  logic          accept;

  assign off    = AW'({idx, 1'b0});
  assign last   = (idx == IW'(NUM_MSG - 1));
  assign accept = start && (state == S_IDLE || state == S_DONE);

  function automatic logic [15:0] encode(input logic [11:1] d);
    logic [15:0] c;
    c       = '0;
    c[15:9] = d[11:5];
    c[8]    = ^d[11:5];
    c[7:5]  = d[4:2];
    c[4]    = (^d[11:8]) ^ (^d[4:2]);
    c[3]    = d[1];
    c[2]    = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    c[1]    = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    c[0]    = ^c[15:1];
    return c;
  endfunction

  // Result packs {flags, 3'b000, d11..d9, d8..d1}; a double error leaves data uncorrected.
  function automatic logic [15:0] decode(input logic [15:0] w);
    logic [3:0]  s;
    logic [15:0] c;
    logic [1:0]  f;
    s = '0;
    for (int k = 1; k < 16; k++) begin
      if (w[k]) s = s ^ 4'(k);
    end
    c = w;
    f = 2'b00;
    if (^w) begin
      c[s] = ~c[s];
      f    = 2'b01;
    end else if (s != 4'd0) begin
      f = 2'b10;
    end
    return {f, 3'b000, c[15:13], c[12:9], c[7:5], c[3]};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_RD_LO;
      S_RD_LO:        state_nx = S_RD_HI;
      S_RD_HI:        state_nx = S_CAP;
      S_CAP:          state_nx = S_WR_LO;
      S_WR_LO:        state_nx = S_WR_HI;
      S_WR_HI:        state_nx = last ? S_DONE : S_RD_LO;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    done        = 1'b0;
    busy        = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      S_RD_LO: begin busy = 1'b1; mem_addr = SRC_A + off; end
      S_RD_HI: begin busy = 1'b1; mem_addr = SRC_A + off + AW'(1); end
      S_CAP:   busy = 1'b1;
      S_WR_LO: begin
        busy = 1'b1; mem_wr_en = 1'b1; mem_addr = DST_A + off; mem_wr_data = res[7:0];
      end
      S_WR_HI: begin
        busy = 1'b1; mem_wr_en = 1'b1; mem_addr = DST_A + off + AW'(1); mem_wr_data = res[15:8];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx    <= '0;
      mode_r <= 1'b0;
      lo_r   <= '0;
      res    <= '0;
    end else begin
      if (accept) begin
        idx    <= '0;
        mode_r <= mode;
      end
      if (state == S_RD_HI) lo_r <= mem_rd_data;
      if (state == S_CAP)
        res <= mode_r ? decode({mem_rd_data, lo_r}) : encode({mem_rd_data[2:0], lo_r});
      if (state == S_WR_HI && !last) idx <= idx + 1'b1;
    end
  end

`ifdef HAMMING_STATS_EN
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      err1_cnt <= '0;
      err2_cnt <= '0;
    end else if (state == S_WR_HI && mode_r) begin
      if (res[15:14] == 2'b01) err1_cnt <= err1_cnt + 1'b1;
      if (res[15:14] == 2'b10) err2_cnt <= err2_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_mem_engine.sv
// Scoreboard bench for hamming_mem_engine with a positional Hamming reference model.
module tb_hamming_mem_engine;
  localparam int N   = 15;
  localparam int SRC = 0;
  localparam int DST = 30;
  localparam int IW  = $clog2(N + 1);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode  = 1'b0;
  logic       done, busy, mem_wr_en;
  logic [7:0] mem_addr, mem_wr_data;
  logic [7:0] mem_rd_data = 8'h00;
`ifdef HAMMING_STATS_EN
  logic [IW-1:0] err1_cnt, err2_cnt;
`endif

  logic [7:0] mem [0:255];
  int tests  = 0;
  int failed = 0;
  int wr_count = 0;
  int exp_e1, exp_e2;

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t exp_q[$];

  hamming_mem_engine #(.NUM_MSG(N), .AW(8), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .done(done), .busy(busy), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
`ifdef HAMMING_STATS_EN
    , .err1_cnt(err1_cnt), .err2_cnt(err2_cnt)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Data bits fill the non-power-of-two positions in order; parity p covers positions with bit p set.
  function automatic logic [15:0] m_encode(input logic [10:0] d);
    logic [15:0] cw;
    int j;
    logic x;
    cw = '0;
    j = 0;
    for (int k = 1; k < 16; k++)
      if ((k & (k - 1)) != 0) begin cw[k] = d[j]; j++; end
    for (int p = 1; p < 16; p = p * 2) begin
      x = 1'b0;
      for (int k = 1; k < 16; k++) if ((k & p) != 0 && k != p) x = x ^ cw[k];
      cw[p] = x;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [15:0] m_decode(input logic [15:0] w);
    int s;
    int j;
    logic [1:0] f;
    logic [10:0] d;
    s = 0;
    for (int k = 1; k < 16; k++) if (w[k]) s = s ^ k;
    if (^w) begin f = 2'b01; w[s] = ~w[s]; end
    else if (s != 0) f = 2'b10;
    else f = 2'b00;
    j = 0;
    d = '0;
    for (int k = 1; k < 16; k++)
      if ((k & (k - 1)) != 0) begin d[j] = w[k]; j++; end
    return {f, 3'b000, d};
  endfunction

  always @(negedge clock) begin
    if (mem_wr_en) begin
      wr_t e;
      wr_count++;
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wr_data), 32'(e.data));
      end
    end
  end

  task automatic push_expected(input logic m);
    logic [15:0] r;
    wr_t e;
    exp_e1 = 0;
    exp_e2 = 0;
    for (int i = 0; i < N; i++) begin
      if (m) begin
        r = m_decode({mem[SRC + 2*i + 1], mem[SRC + 2*i]});
        if (r[15:14] == 2'b01) exp_e1++;
        if (r[15:14] == 2'b10) exp_e2++;
      end else begin
        r = m_encode({mem[SRC + 2*i + 1][2:0], mem[SRC + 2*i]});
      end
      e.addr = 8'(DST + 2*i);     e.data = r[7:0];  exp_q.push_back(e);
      e.addr = 8'(DST + 2*i + 1); e.data = r[15:8]; exp_q.push_back(e);
    end
  endtask

  task automatic run(input logic m, input int poke_cyc);
    int cyc;
    bit seen;
    push_expected(m);
    wr_count = 0;
    @(negedge clock);
    start = 1'b1;
    mode  = m;
    cyc   = 0;
    seen  = 0;
    while (!seen && cyc < 5*N + 20) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (cyc == poke_cyc) begin start = 1'b1; mode = ~m; end
      if (cyc == 1) check("busy_after_start", 32'(busy), 1);
      if (done) seen = 1;
    end
    check("done_latency", cyc, 5*N + 1);
    check("write_count", wr_count, 2*N);
    check("queue_drained", exp_q.size(), 0);
    check("busy_at_done", 32'(busy), 0);
`ifdef HAMMING_STATS_EN
    check("err1_cnt", 32'(err1_cnt), exp_e1);
    check("err2_cnt", 32'(err2_cnt), exp_e2);
`endif
  endtask

  task automatic fill_random_src();
    for (int i = 0; i < 2*N; i++) mem[SRC + i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    logic [15:0] cw;
    int b1, b2, nerr;
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_en", 32'(mem_wr_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wr_data", 32'(mem_wr_data), 0);
    reset = 1'b0;

    // Encode: spec vectors in messages 0..3, random elsewhere.
    fill_random_src();
    mem[0] = 8'h01; mem[1] = 8'h00;
    mem[2] = 8'hFF; mem[3] = 8'h07;
    mem[4] = 8'h00; mem[5] = 8'h00;
    mem[6] = 8'h01; mem[7] = 8'hF8;
    run(1'b0, 0);
    check("enc_001_lo", 32'(mem[30]), 32'h0F);
    check("enc_001_hi", 32'(mem[31]), 32'h00);
    check("enc_7ff_lo", 32'(mem[32]), 32'hFF);
    check("enc_7ff_hi", 32'(mem[33]), 32'hFF);
    check("enc_000_hi", 32'(mem[35]), 32'h00);
    check("enc_stray_lo", 32'(mem[36]), 32'h0F);
    check("enc_stray_hi", 32'(mem[37]), 32'h00);

    // Decode with 0/1/2 injected errors, a spurious start mid-run, restart from DONE.
    for (int i = 0; i < N; i++) begin
      cw = m_encode(11'($urandom_range(0, 2047)));
      nerr = $urandom_range(0, 2);
      b1 = $urandom_range(0, 15);
      b2 = (b1 + $urandom_range(1, 15)) % 16;
      if (nerr >= 1) cw[b1] = ~cw[b1];
      if (nerr == 2) cw[b2] = ~cw[b2];
      mem[SRC + 2*i] = cw[7:0];
      mem[SRC + 2*i + 1] = cw[15:8];
    end
    mem[0] = 8'h0F; mem[1] = 8'h02;
    mem[2] = 8'h0E; mem[3] = 8'h00;
    mem[4] = 8'h0C; mem[5] = 8'h00;
    mem[6] = 8'h0F; mem[7] = 8'h00;
    run(1'b1, 12);
    check("dec_bit9_lo", 32'(mem[30]), 32'h01);
    check("dec_bit9_hi", 32'(mem[31]), 32'h40);
    check("dec_p0_hi", 32'(mem[33]), 32'h40);
    check("dec_dbl_lo", 32'(mem[34]), 32'h01);
    check("dec_dbl_hi", 32'(mem[35]), 32'h80);
    check("dec_clean_hi", 32'(mem[37]), 32'h00);
    repeat (8) @(negedge clock);
    check("done_held", 32'(done), 1);
    check("busy_idle_after_done", 32'(busy), 0);

    // Reset during WR_LO of message 3 aborts; a fresh run then covers every message.
    fill_random_src();
    push_expected(1'b0);
    @(negedge clock);
    start = 1'b1; mode = 1'b0;
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (!(mem_wr_en && mem_addr == 8'(DST + 6)) && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check("reached_msg3_wr_lo", 32'(guard < 100), 1);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("abort_done", 32'(done), 0);
    check("abort_busy", 32'(busy), 0);
`ifdef HAMMING_STATS_EN
    check("abort_err1", 32'(err1_cnt), 0);
`endif
    reset = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clock);
    check("idle_after_abort", 32'(busy), 0);
    run(1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
